result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/seg7_decode.sv | 35 +++
 rtl/result_display.sv | 203 ++++++++++++++++++++
 tb/tb_result_display.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator result path.
//   RESULT_W / MAG_W / BCD_W : widths of the sign-magnitude result, its
//                              magnitude field and the two-digit BCD value.
//   state_t                  : conversion FSM states (IDLE, CONVERT).
//   digit_t                  : which display digit the scanner has selected.
//   SEG_BLANK / SEG_MINUS    : segment patterns {g,f,e,d,c,b,a}, active-high.
//   SEG_DIGIT[0..9]          : segment patterns for decimal digits.
//   an_for()                 : active-low digit enable for a selected digit.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int RESULT_W = 5;
    localparam int MAG_W    = 4;
    localparam int BCD_W    = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_SIGN  = 2'd2
    } digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Element 0 sits in the least significant position, so SEG_DIGIT[d]
    // is the pattern for decimal digit d.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // an[2] = sign, an[1] = tens, an[0] = units; exactly one bit low.
    function automatic logic [2:0] an_for(input digit_t d);
        logic [2:0] a;
        case (d)
            DIG_UNITS: a = 3'b110;
            DIG_TENS:  a = 3'b101;
            DIG_SIGN:  a = 3'b011;
            default:   a = 3'b110;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational BCD to seven-segment decoder.
//   bcd   in  4 : BCD digit 0..9 (codes 10..15 decode to blank)
//   blank in  1 : force all segments off (leading-zero suppression)
//   seg   out 7 : segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
// Accepts a sign-magnitude calculator result over a valid/ready handshake,
// converts the magnitude to two BCD digits with a bit-serial double dabble
// (4 cycles), and drives a multiplexed 3-digit seven-segment display
// (sign, tens, units) with a free-running scan.
//
// Parameters
//   SCAN_DIV  : clock cycles each digit stays enabled per scan step (2..65535)
// Ports
//   clk       in   1 : system clock, rising edge
//   rst_n     in   1 : asynchronous assert, active-low reset
//   in_valid  in   1 : in_result holds a new result
//   in_ready  out  1 : high while idle; a result transfers when both are high
//   in_result in   5 : [4] sign (1 = negative), [3:0] magnitude
//   seg       out  7 : segments {g,f,e,d,c,b,a}, active-high, registered
//   an        out  3 : digit enables, active-low, [2] sign [1] tens [0] units
// ---------------------------------------------------------------------------
module result_display
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RESULT_W-1:0] in_result,
    output logic [6:0]          seg,
    output logic [2:0]          an
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // -----------------------------------------------------------------------
    // Conversion state
    // -----------------------------------------------------------------------
    state_t             state_reg;
    logic [1:0]         shift_cnt_reg;
    logic [MAG_W-1:0]   mag_reg;        // magnitude, shifted out MSB first
    logic               neg_reg;        // sign already cleared for -0
    logic [BCD_W-1:0]   bcd_reg;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic               convert_done;

    // -----------------------------------------------------------------------
    // Displayed value and scan state
    // -----------------------------------------------------------------------
    logic               disp_neg_reg;
    logic [3:0]         disp_tens_reg;
    logic [3:0]         disp_units_reg;
    logic               disp_neg_next;
    logic [3:0]         disp_tens_next;
    logic [3:0]         disp_units_next;

    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [SCAN_W-1:0]  scan_cnt_next;
    logic               scan_wrap;
    digit_t             digit_reg;
    digit_t             digit_next;

    logic [3:0]         dec_bcd;
    logic               dec_blank;
    logic [6:0]         dec_seg;
    logic [6:0]         seg_next;
    logic [2:0]         an_next;

    assign in_ready = (state_reg == IDLE);

    // -----------------------------------------------------------------------
    // Double dabble step: add 3 to every BCD nibble that is 5 or more, then
    // shift left bringing in the next magnitude bit.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BCD_W / 4; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // The bit shifted out of the top is always zero for a 4-bit magnitude.
    assign bcd_shifted  = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, mag_reg[MAG_W-1]};
    assign convert_done = (state_reg == CONVERT) && (shift_cnt_reg == 2'd3);

    // -----------------------------------------------------------------------
    // Conversion FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_cnt_reg <= 2'd0;
            mag_reg       <= '0;
            neg_reg       <= 1'b0;
            bcd_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // qualifies the transfer here.
                    if (in_valid) begin
                        state_reg     <= CONVERT;
                        shift_cnt_reg <= 2'd0;
                        mag_reg       <= in_result[MAG_W-1:0];
                        neg_reg       <= in_result[RESULT_W-1] & (|in_result[MAG_W-1:0]);
                        bcd_reg       <= '0;
                    end
                end
                CONVERT: begin
                    bcd_reg       <= bcd_shifted;
                    mag_reg       <= {mag_reg[MAG_W-2:0], 1'b0};
                    shift_cnt_reg <= shift_cnt_reg + 2'd1;
                    if (shift_cnt_reg == 2'd3) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Displayed value: loaded from the final shift result directly so it is
    // visible on the same edge that ends the conversion.
    // -----------------------------------------------------------------------
    always_comb begin
        disp_neg_next   = disp_neg_reg;
        disp_tens_next  = disp_tens_reg;
        disp_units_next = disp_units_reg;
        if (convert_done) begin
            disp_neg_next   = neg_reg;
            disp_tens_next  = bcd_shifted[7:4];
            disp_units_next = bcd_shifted[3:0];
        end
    end

    // -----------------------------------------------------------------------
    // Scan counter and digit selection
    // -----------------------------------------------------------------------
    assign scan_wrap     = (scan_cnt_reg == SCAN_LAST);
    assign scan_cnt_next = scan_wrap ? '0 : scan_cnt_reg + SCAN_W'(1);

    always_comb begin
        digit_next = digit_reg;
        if (scan_wrap) begin
            case (digit_reg)
                DIG_UNITS: digit_next = DIG_TENS;
                DIG_TENS:  digit_next = DIG_SIGN;
                default:   digit_next = DIG_UNITS;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Segment generation. Both seg and an are computed from digit_next and
    // the next displayed value, so they switch together and a conversion
    // finishing on a scan wrap shows up on the newly selected digit at once.
    // -----------------------------------------------------------------------
    assign dec_bcd   = (digit_next == DIG_TENS) ? disp_tens_next : disp_units_next;
    assign dec_blank = (digit_next == DIG_TENS) && (disp_tens_next == 4'd0);

    seg7_decode u_seg7_decode (
        .bcd   (dec_bcd),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
        if (digit_next == DIG_SIGN) begin
            seg_next = disp_neg_next ? SEG_MINUS : SEG_BLANK;
        end
    end

    assign an_next = an_for(digit_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_neg_reg   <= 1'b0;
            disp_tens_reg  <= 4'd0;
            disp_units_reg <= 4'd0;
            scan_cnt_reg   <= '0;
            digit_reg      <= DIG_UNITS;
            seg            <= SEG_DIGIT[0];
            an             <= 3'b110;
        end else begin
            disp_neg_reg   <= disp_neg_next;
            disp_tens_reg  <= disp_tens_next;
            disp_units_reg <= disp_units_next;
            scan_cnt_reg   <= scan_cnt_next;
            digit_reg      <= digit_next;
            seg            <= seg_next;
            an             <= an_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// ---------------------------------------------------------------------------
// tb_result_display
// Self-checking bench for result_display with SCAN_DIV = 4. The expected
// display is derived from the signed integer value of each accepted result
// using decimal arithmetic and a segment lookup table.
// ---------------------------------------------------------------------------
module tb_result_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_result = 5'd0;
    logic       in_ready;
    logic [6:0] seg;
    logic [2:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    int model_val = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int result_to_int(input logic [4:0] r);
        int mag;
        mag = int'(r[3:0]);
        return r[4] ? -mag : mag;
    endfunction

    // digit: 0 units, 1 tens, 2 sign
    function automatic logic [6:0] exp_seg(input int digit, input int v);
        int mag;
        mag = (v < 0) ? -v : v;
        case (digit)
            0:       return seg_tab[mag % 10];
            1:       return ((mag / 10) == 0) ? 7'h00 : seg_tab[mag / 10];
            default: return (v < 0) ? 7'h40 : 7'h00;
        endcase
    endfunction

    function automatic int digit_of_an(input logic [2:0] a);
        case (a)
            3'b110:  return 0;
            3'b101:  return 1;
            3'b011:  return 2;
            default: return -1;
        endcase
    endfunction

    // Watch a full scan cycle, checking every sampled cycle.
    task automatic check_display(input string tag);
        int d;
        for (int k = 0; k < 3 * SCAN_DIV; k++) begin
            d = digit_of_an(an);
            n_checks++;
            if (d < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: an=%b required one of 110/101/011", tag, an);
            end else if (seg !== exp_seg(d, model_val)) begin
                n_fail++;
                $display("FAIL %s seg_digit%0d: seg=%h required %h (value %0d)",
                         tag, d, seg, exp_seg(d, model_val), model_val);
            end
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [4:0] r, input string tag);
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: in_ready=%b required 1 within 20 cycles", tag, in_ready);
        end
        in_valid  = 1'b1;
        in_result = r;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_cycle%0d: in_ready=%b required 0", tag, i + 1, in_ready);
            end
            // junk on in_result while busy must be ignored
            if (i < 3) in_result = 5'($urandom);
            else       in_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_return: in_ready=%b required 1", tag, in_ready);
        end
        model_val = result_to_int(r);
        $display("txn %s: in_result=%b value=%0d", tag, r, model_val);
        check_display(tag);
    endtask

    task automatic test_scan();
        logic [2:0] exp_an;
        for (int k = 0; k < 16; k++) begin
            case ((k / SCAN_DIV) % 3)
                0:       exp_an = 3'b110;
                1:       exp_an = 3'b101;
                default: exp_an = 3'b011;
            endcase
            n_checks++;
            if (an !== exp_an) begin
                n_fail++;
                $display("FAIL scan_an step%0d: an=%b required %b", k, an, exp_an);
            end else if (seg !== exp_seg(digit_of_an(exp_an), model_val)) begin
                n_fail++;
                $display("FAIL scan_seg step%0d: seg=%h required %h", k, seg,
                         exp_seg(digit_of_an(exp_an), model_val));
            end
            @(negedge clk);
        end
        $display("txn scan: 16 cycles observed");
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_an: an=%b required 110", an);
        end
        n_checks++;
        if (seg !== 7'h3F) begin
            n_fail++;
            $display("FAIL reset_seg: seg=%h required 3f", seg);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 0;
        $display("txn reset: asynchronous reset mid-scan");
    endtask

    task automatic test_back_to_back();
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        in_valid  = 1'b1;
        in_result = 5'b0_0011;
        @(negedge clk);
        in_result = 5'b1_0100;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_first_busy%0d: in_ready=%b required 0", i + 1, in_ready);
            end
            @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_return: in_ready=%b required 1", in_ready);
        end
        model_val = 3;
        n_checks++;
        if (seg !== exp_seg(digit_of_an(an), model_val)) begin
            n_fail++;
            $display("FAIL b2b_first_value: seg=%h required %h", seg, exp_seg(digit_of_an(an), model_val));
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_second_busy%0d: in_ready=%b required 0", i + 1, in_ready);
            end
            @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_return: in_ready=%b required 1", in_ready);
        end
        model_val = -4;
        $display("txn back_to_back: +3 then -4");
        check_display("b2b");
    endtask

    task automatic test_abort();
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        in_valid  = 1'b1;
        in_result = 5'b0_0111;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 0;
        $display("txn abort: reset during conversion of +7");
        check_display("abort");
        send(5'b0_0010, "after_abort");
    endtask

    task automatic test_random();
        logic [4:0] r;
        int gap;
        for (int t = 0; t < 20; t++) begin
            r   = 5'($urandom_range(0, 31));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_result = 5'($urandom);
                @(negedge clk);
            end
            send(r, "random");
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_scan();
        test_reset();
        // first edge after reset release must accept
        send(5'b1_1001, "minus9");
        send(5'b0_1111, "plus15");
        send(5'b1_0000, "neg_zero");
        test_back_to_back();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
